// File: rtl/axi4_capture_pkg.sv
// Shared types and helpers for the packet-capture FIFO.
package axi4_capture_pkg;

    typedef enum logic {
        StAccept = 1'b0,
        StDrop   = 1'b1
    } state_e;

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi4_packet_capture_ram.sv
// Capture storage: one synchronous write port, one asynchronous read port.
module axi4_packet_capture_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi4_s_packet_capture.sv
// Packet-granular capture FIFO: a non-backpressurable debug stream in, AXI4-Stream out.
// Packets that do not fit are dropped whole and counted.
module axi4_s_packet_capture
    import axi4_capture_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int DEPTH      = 16,
    parameter int COUNT_SIZE = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_SIZE-1:0]  s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic [DATA_SIZE-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  overflow_clear,
    output logic                  overflow,
    output logic [COUNT_SIZE-1:0] drop_count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      commit_ptr;
    logic [PW-1:0]      rd_ptr;
    state_e             state;
    logic               full;
    logic               wr_en;
    logic               drop_beat;
    logic               rd_fire;
    logic [DATA_SIZE:0] rd_entry;

    // Occupancy counts the uncommitted tail as well, so a packet never outgrows the storage.
    assign full      = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign wr_en     = (state == StAccept) && s_valid && !full;
    assign drop_beat = (state == StAccept) && s_valid && full;
    assign rd_fire   = m_axis_tvalid && m_axis_tready;

    assign m_axis_tvalid = (rd_ptr != commit_ptr);
    assign m_axis_tdata  = m_axis_tvalid ? rd_entry[DATA_SIZE-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid & rd_entry[DATA_SIZE];

    axi4_packet_capture_ram #(
        .WIDTH (DATA_SIZE + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_last, s_data}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            state      <= StAccept;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // A fresh drop takes priority over a clear request in the same cycle.
            if (drop_beat) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end

            if (drop_beat && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end

            case (state)
                StAccept: begin
                    if (s_valid) begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (s_last) begin
                                commit_ptr <= wr_ptr + 1'b1;
                            end
                        end else begin
                            // Throw away the partial packet already written.
                            wr_ptr <= commit_ptr;
                            if (!s_last) begin
                                state <= StDrop;
                            end
                        end
                    end
                end
                StDrop: begin
                    if (s_valid && s_last) begin
                        state <= StAccept;
                    end
                end
                default: state <= StAccept;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_s_packet_capture.sv
// Scoreboard bench for axi4_s_packet_capture: kept beats are queued when driven and popped at the output.
module tb_axi4_s_packet_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic          overflow_clear = 1'b0;
    logic          overflow;
    logic [CW-1:0] drop_count;

    int tests_run = 0;
    int fails = 0;
    int exp_drops = 0;
    int recv_beats = 0;
    logic [DW:0] sb[$];
    bit mon_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    int rnd_sent;
    bit rnd_done;
    bit rnd_stuck;

    axi4_s_packet_capture #(
        .DATA_SIZE  (DW),
        .DEPTH      (DEPTH),
        .COUNT_SIZE (CW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .overflow_clear (overflow_clear),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 aclk = ~aclk;

    // Output monitor: pops the scoreboard on every transfer, checks stall stability and idle zeros.
    always @(negedge aclk) begin
        logic [DW:0] exp_beat;
        if (!mon_en || !aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests_run++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    fails++;
                    $display("FAIL stall_stable: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (!m_axis_tvalid) begin
                tests_run++;
                if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_zero: got data=%h last=%b, want data=0 last=0",
                             m_axis_tdata, m_axis_tlast);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got data=%h last=%b, want no beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    exp_beat = sb.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== exp_beat) begin
                        fails++;
                        $display("FAIL beat: got data=%h last=%b, want data=%h last=%b",
                                 m_axis_tdata, m_axis_tlast, exp_beat[DW-1:0], exp_beat[DW]);
                    end else begin
                        $display("[TB] beat data=%h last=%b", m_axis_tdata, m_axis_tlast);
                    end
                end
                recv_beats++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic send_packet(input int len, input logic [DW-1:0] base, input bit keep);
        logic lst;
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            if (keep) sb.push_back({lst, base + DW'(i)});
            send_beat(base + DW'(i), lst);
        end
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 500 && sb.size() != 0; i++) begin
            @(posedge aclk);
            #1;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge aclk);
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b, want 0/0/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        tests_run++;
        if (overflow !== 1'b0 || drop_count !== '0) begin
            fails++;
            $display("FAIL reset_status: got overflow=%b drops=%0d, want 0/0", overflow, drop_count);
        end
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic;
        bit ok;
        m_axis_tready = 1'b1;
        sb.push_back({1'b0, 32'hA0});
        send_beat(32'hA0, 1'b0);
        sb.push_back({1'b0, 32'hA1});
        send_beat(32'hA1, 1'b0);
        sb.push_back({1'b1, 32'hA2});
        s_valid = 1'b1;
        s_data  = 32'hA2;
        s_last  = 1'b1;
        @(negedge aclk);
        tests_run++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL latency_pre: got tvalid=%b, want 0", m_axis_tvalid);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge aclk);
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA0) begin
            fails++;
            $display("FAIL latency_first: got valid=%b data=%h, want valid=1 data=000000a0",
                     m_axis_tvalid, m_axis_tdata);
        end
        @(posedge aclk);
        #1;
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: got pending=%0d tvalid=%b, want 0/0", sb.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_long_drop;
        bit ok;
        m_axis_tready = 1'b0;
        send_packet(20, 32'h100, 1'b0);
        exp_drops++;
        @(posedge aclk);
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL long_no_valid: got tvalid=%b, want 0", m_axis_tvalid);
        end
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL long_counters: got overflow=%b drops=%0d, want 1/%0d", overflow, drop_count, exp_drops);
        end
        send_packet(4, 32'h200, 1'b1);
        m_axis_tready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL long_follow_drain: got pending=%0d tvalid=%b, want 0/0", sb.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_partial_drop;
        bit ok;
        m_axis_tready = 1'b0;
        send_packet(4, 32'h300, 1'b1);
        send_packet(14, 32'h400, 1'b0);
        exp_drops++;
        tests_run++;
        if (drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL partial_drops: got %0d, want %0d", drop_count, exp_drops);
        end
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h300) begin
            fails++;
            $display("FAIL partial_head: got valid=%b data=%h, want 1/00000300", m_axis_tvalid, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL partial_drain: got pending=%0d tvalid=%b, want 0/0", sb.size(), m_axis_tvalid);
        end
        // A full-depth packet only fits if the aborted tail was rewound.
        m_axis_tready = 1'b0;
        send_packet(DEPTH, 32'h500, 1'b1);
        tests_run++;
        if (drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL rewind_fit: got drops=%0d, want %0d", drop_count, exp_drops);
        end
        m_axis_tready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL rewind_drain: got pending=%0d tvalid=%b, want 0/0", sb.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_random;
        bit ok;
        int recv_start;
        recv_start = recv_beats;
        rnd_sent  = 0;
        rnd_done  = 1'b0;
        rnd_stuck = 1'b0;
        fork
            begin
                for (int p = 0; p < 100; p++) begin
                    int len;
                    int w;
                    len = $urandom_range(1, 8);
                    // Keep occupancy low enough that no packet can hit full.
                    for (w = 0; w < 300 && (rnd_sent - (recv_beats - recv_start)) > 8; w++) begin
                        @(posedge aclk);
                        #1;
                    end
                    if (w >= 300) rnd_stuck = 1'b1;
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            s_data = $urandom;
                            s_last = 1'($urandom_range(0, 1));
                            @(posedge aclk);
                            #1;
                            s_last = 1'b0;
                        end
                        sb.push_back({(i == len - 1), DW'(32'h1000 + p * 16 + i)});
                        send_beat(DW'(32'h1000 + p * 16 + i), (i == len - 1));
                        rnd_sent++;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    @(posedge aclk);
                    #1;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || rnd_stuck || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: got pending=%0d stuck=%b tvalid=%b, want 0/0/0",
                     sb.size(), rnd_stuck, m_axis_tvalid);
        end
        tests_run++;
        if (drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL random_drops: got %0d, want %0d", drop_count, exp_drops);
        end
    endtask

    task automatic test_overflow_clear;
        bit ok;
        m_axis_tready = 1'b0;
        send_packet(DEPTH, 32'h600, 1'b1);
        send_packet(1, 32'h700, 1'b0);
        exp_drops++;
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL ovf_set: got overflow=%b drops=%0d, want 1/%0d", overflow, drop_count, exp_drops);
        end
        overflow_clear = 1'b1;
        @(posedge aclk);
        #1;
        overflow_clear = 1'b0;
        tests_run++;
        if (overflow !== 1'b0 || drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL ovf_clear: got overflow=%b drops=%0d, want 0/%0d", overflow, drop_count, exp_drops);
        end
        overflow_clear = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 32'h701;
        @(posedge aclk);
        #1;
        overflow_clear = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_drops++;
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL ovf_drop_wins: got overflow=%b drops=%0d, want 1/%0d", overflow, drop_count, exp_drops);
        end
        m_axis_tready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL ovf_drain: got pending=%0d tvalid=%b, want 0/0", sb.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_reset_midstream;
        bit ok;
        m_axis_tready = 1'b0;
        send_packet(2, 32'h800, 1'b1);
        tests_run++;
        if (m_axis_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL mid_pending: got tvalid=%b, want 1", m_axis_tvalid);
        end
        send_packet(3, 32'h900, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h903;
        #2;
        mon_en  = 1'b0;
        aresetn = 1'b0;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_out: got valid=%b data=%h last=%b, want 0/0/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        tests_run++;
        if (overflow !== 1'b0 || drop_count !== '0) begin
            fails++;
            $display("FAIL mid_reset_status: got overflow=%b drops=%0d, want 0/0", overflow, drop_count);
        end
        sb.delete();
        exp_drops = 0;
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send_packet(2, 32'hA00, 1'b1);
        wait_drain(ok);
        tests_run++;
        if (!ok || m_axis_tvalid !== 1'b0 || drop_count !== CW'(exp_drops)) begin
            fails++;
            $display("FAIL mid_post_reset: got pending=%0d tvalid=%b drops=%0d, want 0/0/0",
                     sb.size(), m_axis_tvalid, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_drop();
        test_partial_drop();
        test_random();
        test_overflow_clear();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
